rv32i_core: RTL and testbench

Multi-cycle (non-pipelined) RV32I integer core with separate Wishbone-style instruction-fetch and data-memory master ports. Each instruction is fetched, executed, optionally accesses memory, and is written back before the next fetch begins. The core is the processor root of the SoC, and the memory system attaches directly to its two bus ports.

---
 rtl/rv32i_pkg.sv | 57 +++++
 rtl/rv32i_regfile.sv | 32 +++
 rtl/rv32i_core.sv | 195 +++++++++++++++++++
 tb/tb_rv32i_core.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i_core multi-cycle RV32I processor.
package rv32i_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // funct3 for OP / OP_IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 for word-sized LOAD / STORE (the only width supported)
    localparam logic [2:0] F3_W    = 3'b010;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;

    // Map funct3 to an ALU operation; sub selects SUB over ADD, sra selects SRA over SRL
    function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic sub, input logic sra);
        case (funct3)
            F3_ADD:  return sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return sra ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 integer register file: two asynchronous read ports, one synchronous write port.
module rv32i_regfile
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);

    logic [31:0] regs [0:31];

    // Register write port; x0 is never written so it stays at its reset value of 0
    // NOTE: the whole array is cleared on reset because software may read any register before writing it;
    //       sequential state is always updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_en && (rd_addr != 5'd0)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

endmodule

// File: rtl/rv32i_core.sv
// Multi-cycle RV32I core: FETCH -> EXEC -> (MEM) -> WB, separate fetch and data bus masters.
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_addr,
    output logic        o_stb_inst,
    input  logic        i_ack,
    output logic        o_wb_stb_data,
    output logic        o_wb_cyc_data,
    output logic        o_wb_we_data,
    output logic [31:0] o_wb_addr_data,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack_data,
    input  logic [31:0] i_wb_data
);

    state_t      state;
    logic [31:0] pc, ir, next_pc, result;
    logic        wr_rd;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_data, rs2_data;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'd0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    rv32i_regfile u_regfile (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .rs1_addr (ir[19:15]),
        .rs2_addr (ir[24:20]),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    ((state == WB) && wr_rd),
        .rd_addr  (ir[11:7]),
        .rd_data  (result)
    );

    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_y;

    // ALU: rs1 against rs2 (OP) or immI (everything else)
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        alu_b  = (opcode == OP) ? rs2_data : imm_i;
        alu_op = alu_decode(funct3, (opcode == OP) && ir[30], ir[30]);
        alu_y  = '0;
        case (alu_op)
            ALU_ADD:  alu_y = rs1_data + alu_b;
            ALU_SUB:  alu_y = rs1_data - alu_b;
            ALU_SLL:  alu_y = rs1_data << alu_b[4:0];
            ALU_SLT:  alu_y = {31'd0, $signed(rs1_data) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, rs1_data < alu_b};
            ALU_XOR:  alu_y = rs1_data ^ alu_b;
            ALU_SRL:  alu_y = rs1_data >> alu_b[4:0];
            ALU_SRA:  alu_y = $unsigned($signed(rs1_data) >>> alu_b[4:0]);
            ALU_OR:   alu_y = rs1_data | alu_b;
            ALU_AND:  alu_y = rs1_data & alu_b;
            default:  alu_y = '0;
        endcase
    end

    logic taken;

    // Branch comparator
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1_data == rs2_data);
            F3_BNE:  taken = (rs1_data != rs2_data);
            F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: taken = (rs1_data <  rs2_data);
            F3_BGEU: taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
    end

    logic [31:0] pc_plus4, ex_next_pc, ex_result, ex_addr;
    logic        ex_wr, ex_mem, ex_store;

    // Instruction decode: writeback value, next PC and memory request; unknown opcodes fall through as NOP
    always_comb begin
        pc_plus4   = pc + 32'd4;
        ex_next_pc = pc_plus4;
        ex_result  = alu_y;
        ex_addr    = rs1_data + imm_i;
        ex_wr      = 1'b0;
        ex_mem     = 1'b0;
        ex_store   = 1'b0;
        case (opcode)
            OP, OP_IMM: ex_wr = 1'b1;
            LUI: begin
                ex_result = imm_u;
                ex_wr     = 1'b1;
            end
            AUIPC: begin
                ex_result = pc + imm_u;
                ex_wr     = 1'b1;
            end
            JAL: begin
                ex_result  = pc_plus4;
                ex_next_pc = pc + imm_j;
                ex_wr      = 1'b1;
            end
            JALR: begin
                ex_result  = pc_plus4;
                ex_next_pc = (rs1_data + imm_i) & ~32'd1;
                ex_wr      = 1'b1;
            end
            BRANCH: if (taken) ex_next_pc = pc + imm_b;
            LOAD: if (funct3 == F3_W) begin
                ex_mem = 1'b1;
                ex_wr  = 1'b1;
            end
            STORE: if (funct3 == F3_W) begin
                ex_mem   = 1'b1;
                ex_store = 1'b1;
                ex_addr  = rs1_data + imm_s;
            end
            default: ;
        endcase
    end

    // Control FSM with registered bus outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            ir             <= '0;
            next_pc        <= RESET_PC;
            result         <= '0;
            wr_rd          <= 1'b0;
            o_stb_inst     <= 1'b0;
            o_wb_stb_data  <= 1'b0;
            o_wb_we_data   <= 1'b0;
            o_wb_addr_data <= '0;
            o_wb_data      <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (o_stb_inst && i_ack) begin
                        ir         <= i_inst;
                        o_stb_inst <= 1'b0;
                        state      <= EXEC;
                    end else begin
                        o_stb_inst <= 1'b1;
                    end
                end
                EXEC: begin
                    next_pc <= ex_next_pc;
                    result  <= ex_result;
                    wr_rd   <= ex_wr;
                    if (ex_mem) begin
                        o_wb_stb_data  <= 1'b1;
                        o_wb_we_data   <= ex_store;
                        o_wb_addr_data <= ex_addr;
                        o_wb_data      <= rs2_data;
                        state          <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (i_wb_ack_data) begin
                        if (!o_wb_we_data) result <= i_wb_data;
                        o_wb_stb_data <= 1'b0;
                        state         <= WB;
                    end
                end
                WB: begin
                    pc    <= next_pc;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign o_addr        = pc;
    assign o_wb_cyc_data = o_wb_stb_data;

endmodule

// File: tb/tb_rv32i_core.sv
// Scoreboard bench for rv32i_core: bus slaves, expected fetch/data queues, and a monitor.
module tb_rv32i_core;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_inst;
    logic [31:0] o_addr;
    logic        o_stb_inst;
    logic        i_ack;
    logic        o_wb_stb_data;
    logic        o_wb_cyc_data;
    logic        o_wb_we_data;
    logic [31:0] o_wb_addr_data;
    logic [31:0] o_wb_data;
    logic        i_wb_ack_data;
    logic [31:0] i_wb_data;

    rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_inst         (i_inst),
        .o_addr         (o_addr),
        .o_stb_inst     (o_stb_inst),
        .i_ack          (i_ack),
        .o_wb_stb_data  (o_wb_stb_data),
        .o_wb_cyc_data  (o_wb_cyc_data),
        .o_wb_we_data   (o_wb_we_data),
        .o_wb_addr_data (o_wb_addr_data),
        .o_wb_data      (o_wb_data),
        .i_wb_ack_data  (i_wb_ack_data),
        .i_wb_data      (i_wb_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; int gap; } fetch_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } data_exp_t;

    fetch_exp_t  fetch_q[$];
    data_exp_t   data_q[$];
    logic [31:0] imem [0:127];
    bit          slave_en;
    bit          prev_mem;

    // Fetch wait states per address: 0x124 stalls 5 cycles, 0x128 is never acknowledged
    function automatic int wait_for(input logic [31:0] a);
        if (a == 32'h124) return 5;
        if (a == 32'h128) return 1000000;
        return 0;
    endfunction

    // Load program word and queue its expected fetch with the cycle gap from the previous fetch
    task automatic add(input logic [31:0] a, input logic [31:0] instr, input bit is_mem);
        fetch_exp_t fe;
        imem[a[8:2]] = instr;
        fe.addr = a;
        fe.gap  = (a == 32'h0) ? 0 : ((prev_mem ? 5 : 4) + wait_for(a));
        fetch_q.push_back(fe);
        prev_mem = is_mem;
    endtask

    task automatic add_data(input logic we, input logic [31:0] a, input logic [31:0] d);
        data_exp_t de;
        de.we = we; de.addr = a; de.data = d;
        data_q.push_back(de);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((fetch_q.size() != 0 || data_q.size() != 0) && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        check(name, fetch_q.size() + data_q.size(), 0);
    endtask

    // Instruction slave
    int stall_cnt;
    initial begin
        i_ack = 1'b0; i_inst = '0; stall_cnt = 0;
        forever begin
            @(negedge clk);
            i_ack = 1'b0;
            if (slave_en && o_stb_inst) begin
                if (stall_cnt >= wait_for(o_addr)) begin
                    i_ack     = 1'b1;
                    i_inst    = imem[o_addr[8:2]];
                    stall_cnt = 0;
                end else begin
                    stall_cnt++;
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    // Data slave: loads return a fixed word and hold ack for three cycles
    int hold_cnt;
    initial begin
        i_wb_ack_data = 1'b0; i_wb_data = '0; hold_cnt = 0;
        forever begin
            @(negedge clk);
            if (hold_cnt > 0) begin
                i_wb_ack_data = 1'b1;
                hold_cnt--;
            end else if (o_wb_stb_data) begin
                i_wb_ack_data = 1'b1;
                i_wb_data     = 32'h1234_5678;
                hold_cnt      = o_wb_we_data ? 0 : 2;
            end else begin
                i_wb_ack_data = 1'b0;
            end
        end
    end

    // Monitor: pops expectations at each handshake and checks that pending requests hold stable
    initial begin
        fetch_exp_t  fe;
        data_exp_t   de;
        logic        pf_pend, pd_pend, pd_we;
        logic [31:0] pf_addr, pd_addr, pd_data;
        int          last_fetch;
        pf_pend = 0; pd_pend = 0; pd_we = 0; pf_addr = 0; pd_addr = 0; pd_data = 0; last_fetch = 0;
        forever begin
            @(negedge clk); #1;
            if (!i_rst) begin
                pf_pend = 0;
                pd_pend = 0;
            end else begin
                if (pf_pend) begin
                    check("fetch_hold_stb", {31'd0, o_stb_inst}, 32'd1);
                    check("fetch_hold_addr", o_addr, pf_addr);
                end
                if (pd_pend) begin
                    check("data_hold_stb", {31'd0, o_wb_stb_data}, 32'd1);
                    check("data_hold_we", {31'd0, o_wb_we_data}, {31'd0, pd_we});
                    check("data_hold_addr", o_wb_addr_data, pd_addr);
                    check("data_hold_data", o_wb_data, pd_data);
                end
                if (o_stb_inst && i_ack) begin
                    if (fetch_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_fetch: got addr %h expected no fetch", o_addr);
                    end else begin
                        fe = fetch_q.pop_front();
                        check("fetch_addr", o_addr, fe.addr);
                        if (fe.gap != 0) check("fetch_gap", cyc_cnt, last_fetch + fe.gap);
                    end
                    last_fetch = cyc_cnt;
                end
                if (o_wb_stb_data && i_wb_ack_data) begin
                    if (data_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_data: got addr %h expected no transfer", o_wb_addr_data);
                    end else begin
                        de = data_q.pop_front();
                        check("data_cyc", {31'd0, o_wb_cyc_data}, 32'd1);
                        check("data_we", {31'd0, o_wb_we_data}, {31'd0, de.we});
                        check("data_addr", o_wb_addr_data, de.addr);
                        if (de.we) check("data_wdata", o_wb_data, de.data);
                    end
                end
                pf_pend = o_stb_inst && !i_ack;
                pf_addr = o_addr;
                pd_pend = o_wb_stb_data && !i_wb_ack_data;
                pd_we   = o_wb_we_data;
                pd_addr = o_wb_addr_data;
                pd_data = o_wb_data;
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        i_rst = 1'b1;
        slave_en = 1'b1;
        prev_mem = 1'b0;
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0013;

        add(32'h000, 32'h0050_0093, 0); // ADDI x1,x0,5
        add(32'h004, 32'h0070_0113, 0); // ADDI x2,x0,7
        add(32'h008, 32'h0020_81B3, 0); // ADD  x3,x1,x2
        add(32'h00C, 32'h4020_8233, 0); // SUB  x4,x1,x2
        add(32'h010, 32'h0030_2423, 1); // SW   x3,8(x0)
        add(32'h014, 32'h0040_2623, 1); // SW   x4,12(x0)
        add(32'h018, 32'h0000_2383, 1); // LW   x7,0(x0)
        add(32'h01C, 32'h0070_2823, 1); // SW   x7,16(x0)
        add(32'h020, 32'h0010_8863, 0); // BEQ  x1,x1,16 -> 0x30
        add(32'h030, 32'h0140_05EF, 0); // JAL  x11,20   -> 0x44
        add(32'h044, 32'h0010_9863, 0); // BNE  x1,x1,16 -> 0x48
        add(32'h048, 32'h00B0_2A23, 1); // SW   x11,20(x0)
        add(32'h04C, 32'hFFF0_0293, 0); // ADDI x5,x0,-1
        add(32'h050, 32'h01C2_D313, 0); // SRLI x6,x5,28
        add(32'h054, 32'h4012_5413, 0); // SRAI x8,x4,1
        add(32'h058, 32'h0050_B4B3, 0); // SLTU x9,x1,x5
        add(32'h05C, 32'h0012_A533, 0); // SLT  x10,x5,x1
        add(32'h060, 32'h0060_2C23, 1); // SW   x6,24(x0)
        add(32'h064, 32'h0080_2E23, 1); // SW   x8,28(x0)
        add(32'h068, 32'h0290_2023, 1); // SW   x9,32(x0)
        add(32'h06C, 32'h02A0_2223, 1); // SW   x10,36(x0)
        add(32'h070, 32'h1010_0667, 0); // JALR x12,x0,0x101 -> 0x100
        add(32'h100, 32'h1234_56B7, 0); // LUI  x13,0x12345
        add(32'h104, 32'h02D0_2423, 1); // SW   x13,40(x0)
        add(32'h108, 32'h02C0_2623, 1); // SW   x12,44(x0)
        add(32'h10C, 32'h0012_C463, 0); // BLT  x5,x1,8  -> 0x114
        add(32'h114, 32'h0012_F463, 0); // BGEU x5,x1,8  -> 0x11C
        add(32'h11C, 32'h0000_1717, 0); // AUIPC x14,1
        add(32'h120, 32'h02E0_2823, 1); // SW   x14,48(x0)
        add(32'h124, 32'h0010_0793, 0); // ADDI x15,x0,1 (fetch stalled 5 cycles)

        add_data(1'b1, 32'h08, 32'h0000_000C);
        add_data(1'b1, 32'h0C, 32'hFFFF_FFFE);
        add_data(1'b0, 32'h00, 32'h0000_0000);
        add_data(1'b1, 32'h10, 32'h1234_5678);
        add_data(1'b1, 32'h14, 32'h0000_0034);
        add_data(1'b1, 32'h18, 32'h0000_000F);
        add_data(1'b1, 32'h1C, 32'hFFFF_FFFF);
        add_data(1'b1, 32'h20, 32'h0000_0001);
        add_data(1'b1, 32'h24, 32'h0000_0001);
        add_data(1'b1, 32'h28, 32'h1234_5000);
        add_data(1'b1, 32'h2C, 32'h0000_0074);
        add_data(1'b1, 32'h30, 32'h0000_111C);

        #1 i_rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_addr", o_addr, 32'h0);
        check("rst_stb_inst", {31'd0, o_stb_inst}, 32'd0);
        check("rst_stb_data", {31'd0, o_wb_stb_data}, 32'd0);
        check("rst_cyc_data", {31'd0, o_wb_cyc_data}, 32'd0);
        check("rst_we_data", {31'd0, o_wb_we_data}, 32'd0);
        check("rst_addr_data", o_wb_addr_data, 32'h0);
        check("rst_wdata", o_wb_data, 32'h0);

        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk); #1;
        check("first_fetch_stb", {31'd0, o_stb_inst}, 32'd1);
        check("first_fetch_addr", o_addr, 32'h0);

        wait_drain(2000, "program_drain");

        // Wait for the never-acknowledged fetch at 0x128, then abort it with reset
        n = 0;
        while (!(o_stb_inst && o_addr == 32'h128) && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        check("stall_fetch_seen", {31'd0, o_stb_inst}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        check("stall_fetch_addr", o_addr, 32'h128);
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        check("abort_stb_inst", {31'd0, o_stb_inst}, 32'd0);
        check("abort_addr", o_addr, 32'h0);
        check("abort_stb_data", {31'd0, o_wb_stb_data}, 32'd0);
        begin
            fetch_exp_t fe;
            fe.addr = 32'h0; fe.gap = 0;
            fetch_q.push_back(fe);
        end
        @(negedge clk);
        i_rst = 1'b1;
        wait_drain(50, "restart_drain");
        slave_en = 1'b0;

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
